sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Command-side driver for an SR latch: accepts a set/clear command over a valid/ready handshake and turns it into a clean, non-overlapping S or R pulse with a configurable dead time and pulse width, then confirms the result on the latch Q feedback. It sits between control logic and any `SR_latch`-style storage element. It guarantees S and R are never asserted together. It reports completion, or a timeout error if Q does not follow the command.

## Interface
- `GAP_W`, default 1: dead cycles, with S=R=0, between accept and pulse; ≥0.
- `PULSE_W`, default 2: cycles S or R is held high; ≥1, elaboration error otherwise.
- `CHK_W`, default 4: maximum cycles to wait for `q_fb` to match the command; ≥1, elaboration error otherwise.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset; priority over all inputs.
- `cmd_valid`  in  1  command present.
- `cmd_val`  in  1  1 = set (drive S), 0 = clear (drive R).
- `cmd_ready`  out  1  high only in IDLE.
- `q_fb`  in  1  latch Q. Synchronous to `clk`; asynchronous sources are synchronized upstream.
- `S`  out  1  latch set, registered.
- `R`  out  1  latch reset, registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on timeout.
- `last_val`  out  1  last successfully written value.

## Operation
- States: IDLE, GAP, PULSE, CHECK. Outputs are Moore-decoded from registered state plus a registered target bit `tgt`.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, capture `tgt`=`cmd_val` and load the dwell counter.
  - Go to GAP, or directly to PULSE if GAP_W=0.
- **GAP**
  - S=R=0.
  - After GAP_W cycles, go to PULSE.
- **PULSE**
  - S=`tgt`, R=~`tgt`.
  - After PULSE_W cycles, go to CHECK.
- **CHECK**
  - S=R=0.
  - Sample `q_fb` at each edge.
  - On the first edge where `q_fb`==`tgt`, go to IDLE with `done`=1, `err`=0, `last_val`←`tgt`.
  - If CHK_W edges pass without a match, go to IDLE with `done`=1, `err`=1; `last_val` is unchanged.
- Invariant: S&R is 0 in every cycle, including reset and the cycle after reset.
- `cmd_valid` while busy is ignored; the requestor holds it.
- `cmd_val` is sampled only at accept; later changes are ignored.
- A command equal to `last_val` still runs the full sequence. No skipping.
- Back-to-back operation: the `done` cycle is an IDLE cycle, so a new command may be accepted in it.

## Timing
- Reset values: state IDLE, S=0, R=0, `done`=0, `err`=0, `last_val`=0, `busy`=0. `cmd_ready`=1 from the first cycle after the reset edge.
- Accept edge = edge 0.
  - S/R high in the cycles following edges GAP_W … GAP_W+PULSE_W−1.
  - First `q_fb` check at edge GAP_W+PULSE_W+1.
- Best-case latency: `done` high in the cycle after edge GAP_W+PULSE_W+1. With defaults, that is 4 edges after accept.
- Timeout latency: `done`&`err` high in the cycle after edge GAP_W+PULSE_W+CHK_W.
- Reset mid-operation:
  - The next cycle is IDLE with S=R=0, `done`=`err`=0, and `last_val` cleared.
  - The command is dropped; no completion is reported.
- `rst` and `cmd_valid` together: reset wins and the command is not accepted.
- Counter width is $clog2(max(GAP_W,PULSE_W,CHK_W)+1). It never wraps because it is reloaded on each state entry.

## Structure
- Shared package/include `sr_drv_pkg` holds:
  - the state encoding localparams (IDLE=0, GAP=1, PULSE=2, CHECK=3);
  - the parameter-legality checks.
- One sub-module is natural: `dwell_timer`, a loadable down-counter with an `expire` flag, instantiated once and reloaded per state.

## Test plan
- Reset, then set with defaults, with `q_fb` following S one cycle later:
  - S high for exactly 2 cycles after 1 dead cycle; R stays 0;
  - `done`=1, `err`=0 at accept+4; `last_val`=1.
- Clear command with `q_fb` stuck at 1:
  - R pulses for 2 cycles;
  - `done`=`err`=1 at accept+7 (1+2+4); `last_val` stays 1.
- Back-to-back set then clear, with the second command held valid during busy:
  - second accept occurs in the `done` cycle;
  - S and R are never high together; no cycle is lost.
- Reset asserted during PULSE:
  - S drops the next cycle; no `done`;
  - `cmd_ready`=1 the following cycle; `last_val`=0.
- GAP_W=0, PULSE_W=1, CHK_W=1, with `cmd_val` toggled after accept:
  - S is high the cycle after accept;
  - the toggle has no effect;
  - `done` at accept+2.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch command driver: state encoding,
// parameter legality and small elaboration-time helpers.
package sr_drv_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GAP   = ST_GAP,
        PULSE = ST_PULSE,
        CHECK = ST_CHECK
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_ok(input int gap_w, input int pulse_w, input int chk_w);
        return (gap_w >= 0) && (pulse_w >= 1) && (chk_w >= 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Turns set/clear commands into non-overlapping S/R pulses with dead time,
// then confirms the latch output and reports done or timeout.
//
// state | meaning
// IDLE  | ready for a command, S=R=0
// GAP   | dead time before the pulse, S=R=0
// PULSE | drive S (tgt=1) or R (tgt=0)
// CHECK | S=R=0, wait for q_fb to equal tgt
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int GAP_W   = 1,
    parameter int PULSE_W = 2,
    parameter int CHK_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_val,
    output logic cmd_ready,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic done,
    output logic err,
    output logic last_val
);

    localparam int CW = $clog2(max3(GAP_W, PULSE_W, CHK_W) + 1);

    generate
        if (!params_ok(GAP_W, PULSE_W, CHK_W)) begin : g_bad_params
            $error("sr_latch_driver: need GAP_W>=0, PULSE_W>=1, CHK_W>=1");
        end
    endgenerate

    // Each dwell loads N-1 so the state lasts exactly N cycles.
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP_W > 0) ? GAP_W - 1 : 0);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] CHK_LD   = CW'(CHK_W - 1);

    state_t        state;
    logic          tgt;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_expire;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = (GAP_W > 0) ? GAP_LD : PULSE_LD;
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = CHK_LD;
                end
            end
            default: ;
        endcase
    end

    dwell_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            last_val <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt <= cmd_val;
                        if (GAP_W == 0) begin
                            state <= PULSE;
                            S     <= cmd_val;
                            R     <= ~cmd_val;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tmr_expire) begin
                        state <= PULSE;
                        S     <= tgt;
                        R     <= ~tgt;
                    end
                end
                PULSE: begin
                    if (tmr_expire) begin
                        state <= CHECK;
                        S     <= 1'b0;
                        R     <= 1'b0;
                    end
                end
                CHECK: begin
                    if (q_fb == tgt) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        last_val <= tgt;
                    end else if (tmr_expire) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: default-parameter instance against an
// offset-from-accept reference model, plus a vector table for GAP_W=0.
module tb_sr_latch_driver;

    localparam int G = 1;
    localparam int P = 2;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic rst = 1'b1, cmd_valid = 1'b0, cmd_val = 1'b0, q_fb = 1'b0;
    logic rdy1, s1, r1, busy1, done1, err1, last1;

    // GAP_W=0, PULSE_W=1, CHK_W=1 instance
    logic rst2 = 1'b1, v2 = 1'b0, val2 = 1'b0, q2 = 1'b0;
    logic rdy2, s2, r2, busy2, done2, err2, last2;

    sr_latch_driver #(.GAP_W(G), .PULSE_W(P), .CHK_W(C)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_val(cmd_val),
        .cmd_ready(rdy1), .q_fb(q_fb), .S(s1), .R(r1), .busy(busy1),
        .done(done1), .err(err1), .last_val(last1)
    );

    sr_latch_driver #(.GAP_W(0), .PULSE_W(1), .CHK_W(1)) dut0 (
        .clk(clk), .rst(rst2), .cmd_valid(v2), .cmd_val(val2),
        .cmd_ready(rdy2), .q_fb(q2), .S(s2), .R(r2), .busy(busy2),
        .done(done2), .err(err2), .last_val(last2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: tracks edges since accept and derives outputs from
    // the timing rules directly.
    bit m_act = 0, m_tgt = 0, m_last = 0, m_done = 0, m_err = 0;
    int m_off = 0;
    bit e_s, e_r;

    task automatic model_step();
        bit pulse;
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_act  = 0;
            m_last = 0;
        end else if (!m_act) begin
            if (cmd_valid) begin
                m_act = 1;
                m_off = 0;
                m_tgt = cmd_val;
            end
        end else begin
            m_off++;
            if (m_off >= G + P + 1) begin
                if (q_fb == m_tgt) begin
                    m_done = 1;
                    m_last = m_tgt;
                    m_act  = 0;
                end else if (m_off == G + P + C) begin
                    m_done = 1;
                    m_err  = 1;
                    m_act  = 0;
                end
            end
        end
        pulse = m_act && (m_off >= G) && (m_off <= G + P - 1);
        e_s = pulse && m_tgt;
        e_r = pulse && !m_tgt;
    endtask

    // q_fb behaviour: 0 = latch following S/R one cycle later, 1 = held
    int  mode = 0;
    bit  pend = 0;

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", {s1, r1, done1, err1, rdy1, busy1, last1},
            {e_s, e_r, m_done, m_err, !m_act, m_act, m_last});
        chk("sr_excl", {s1 & r1, s2 & r2}, 2'b00);
        if (mode == 0) begin
            q_fb = pend;
            if (s1) pend = 1;
            else if (r1) pend = 0;
        end
    endtask

    task automatic run_cmd(input logic val, input int exp_lat, input logic exp_err, input string nm);
        int k;
        bit seen;
        cmd_valid = 1;
        cmd_val   = val;
        cyc();
        cmd_valid = 0;
        cmd_val   = ~val;
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            cyc();
            k++;
            if (done1) seen = 1;
        end
        chk({nm, "_lat"}, k, exp_lat);
        chk({nm, "_err"}, err1, exp_err);
    endtask

    typedef struct {
        logic rst, v, val, q;
        logic s, r, d, e, rdy, last;
    } vec_t;

    function automatic vec_t mk(input logic rst_i, v_i, val_i, q_i,
                                input logic s_i, r_i, d_i, e_i, rdy_i, last_i);
        vec_t t;
        t.rst = rst_i; t.v = v_i; t.val = val_i; t.q = q_i;
        t.s = s_i; t.r = r_i; t.d = d_i; t.e = e_i; t.rdy = rdy_i; t.last = last_i;
        return t;
    endfunction

    vec_t tbl[16];

    initial begin
        int k, n;
        //           rst v val q   S R d e rdy last
        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 1, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 1, 1);
        tbl[4]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 1);
        tbl[5]  = mk(0, 1, 0, 1,  0, 1, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 1,  0, 0, 1, 1, 1, 1);
        tbl[8]  = mk(0, 1, 1, 0,  1, 0, 0, 0, 0, 1);
        tbl[9]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[10] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1, 1);
        tbl[11] = mk(0, 1, 0, 0,  0, 1, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
        tbl[14] = mk(1, 1, 1, 0,  0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

        repeat (2) cyc();
        rst = 0;
        cyc();

        // set with q following S
        mode = 0;
        run_cmd(1'b1, 4, 1'b0, "set");
        chk("set_last", last1, 1);

        // clear with q stuck high: timeout
        mode = 1;
        q_fb = 1;
        run_cmd(1'b0, 7, 1'b1, "clr_stuck");
        chk("clr_stuck_last", last1, 1);

        // back-to-back with second command held during busy
        mode = 0;
        pend = 1;
        cmd_valid = 1;
        cmd_val   = 1;
        cyc();
        cmd_val = 0;
        k = 0;
        n = 0;
        while (n < 2 && k < 30) begin
            cyc();
            k++;
            if (done1) n++;
        end
        cmd_valid = 0;
        chk("b2b_lat", k, 9);
        chk("b2b_last", last1, 0);
        repeat (2) cyc();

        // reset during PULSE
        cmd_valid = 1;
        cmd_val   = 1;
        cyc();
        cmd_valid = 0;
        cyc();
        chk("rst_pulse_s", s1, 1);
        rst = 1;
        cyc();
        chk("rst_s_drop", s1, 0);
        chk("rst_ready", rdy1, 1);
        rst = 0;
        n = 0;
        repeat (8) begin
            cyc();
            if (done1) n++;
        end
        chk("rst_no_done", n, 0);
        chk("rst_last", last1, 0);

        // vector table for the zero-gap instance
        for (int i = 0; i < 16; i++) begin
            rst2 = tbl[i].rst;
            v2   = tbl[i].v;
            val2 = tbl[i].val;
            q2   = tbl[i].q;
            cyc();
            chk($sformatf("tbl%0d", i), {s2, r2, done2, err2, rdy2, last2},
                {tbl[i].s, tbl[i].r, tbl[i].d, tbl[i].e, tbl[i].rdy, tbl[i].last});
        end

        // randomized traffic against the model
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 40) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_val   = 1'($urandom_range(0, 1));
            q_fb      = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
